// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_divider_pkg;

    // Default width of one divisor / high-time field
    localparam int unsigned c_div_width = 16;

    // Divisors below this value keep a channel idle
    localparam int unsigned c_min_div = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // LSB position of channel ch inside a flattened multi-channel bus
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, latched divisor/high time, registered outputs.
// Latency: outputs register one cycle after the edge that loads or advances the count.
// Backpressure: none; the divisor is re-sampled only at period boundaries, on sync or while idle.
module clk_div_channel
    import clock_divider_pkg::*;
#(
    parameter int unsigned p_div_width = c_div_width
) (
    input  logic                   i_w_clk,
    input  logic                   i_w_reset,
    input  logic                   i_w_en,
    input  logic                   i_w_sync,
    input  logic [p_div_width-1:0] i_w_div,
    input  logic [p_div_width-1:0] i_w_high,
    output logic                   o_w_clk,
    output logic                   o_w_tick,
    output logic                   o_w_active
);

    localparam logic [p_div_width-1:0] lp_min_div = p_div_width'(c_min_div);
    localparam logic [p_div_width-1:0] lp_one     = p_div_width'(1);

    ch_state_e              r_state;
    logic [p_div_width-1:0] r_cnt;
    logic [p_div_width-1:0] r_cur_div;
    logic [p_div_width-1:0] r_cur_high;
    logic                   r_clk;
    logic                   r_tick;
    logic                   r_active;

    logic                   w_div_ok;
    logic [p_div_width-1:0] w_high_clamped;
    logic                   w_boundary;
    logic                   w_load;
    logic [p_div_width-1:0] w_cnt_inc;

    assign w_div_ok       = (i_w_div >= lp_min_div);
    // A high time that reaches the divisor would leave no low phase
    assign w_high_clamped = (i_w_high >= i_w_div) ? (i_w_div - lp_one) : i_w_high;
    assign w_boundary     = (r_state == ST_RUN) && (r_cnt == (r_cur_div - lp_one));
    // Sync, idle sampling and the period boundary all collapse into one restart
    assign w_load         = i_w_sync || (r_state == ST_IDLE) || w_boundary;
    assign w_cnt_inc      = r_cnt + lp_one;

    // Channel FSM; outputs are computed from the next count so they line up with it
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cur_div  <= '0;
            r_cur_high <= '0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_active   <= 1'b0;
        end else if (!i_w_en) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
            r_active <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_cur_div <= i_w_div;
            if (w_div_ok) begin
                r_state    <= ST_RUN;
                r_cur_high <= w_high_clamped;
                r_clk      <= (w_high_clamped != '0);
                r_tick     <= 1'b1;
                r_active   <= 1'b1;
            end else begin
                r_state    <= ST_IDLE;
                r_cur_high <= '0;
                r_clk      <= 1'b0;
                r_tick     <= 1'b0;
                r_active   <= 1'b0;
            end
        end else begin
            r_cnt    <= w_cnt_inc;
            r_clk    <= (w_cnt_inc < r_cur_high);
            r_tick   <= 1'b0;
            r_active <= 1'b1;
        end
    end

    assign o_w_clk    = r_clk;
    assign o_w_tick   = r_tick;
    assign o_w_active = r_active;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel run-time programmable clock/tick generator; CLKDIV_DUTY_EN adds a per-channel high-time bus.
// Latency: one cycle from the sampling edge to the first tick of a period.
// Backpressure: none; channels free-run and share only the sync restart strobe.
module prog_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned p_channels  = 4,
    parameter int unsigned p_div_width = c_div_width
) (
    input  logic                              i_w_clk,
    input  logic                              i_w_reset,
    input  logic [p_channels-1:0]             i_w_en,
    input  logic [p_channels*p_div_width-1:0] i_w_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [p_channels*p_div_width-1:0] i_w_high,
`endif
    input  logic                              i_w_sync,
    output logic [p_channels-1:0]             o_w_clk,
    output logic [p_channels-1:0]             o_w_tick,
    output logic [p_channels-1:0]             o_w_active
);

    for (genvar g = 0; g < p_channels; g++) begin : g_ch
        localparam int unsigned lp_lsb = ch_lsb(g, p_div_width);

        logic [p_div_width-1:0] w_div;
        logic [p_div_width-1:0] w_high;

        assign w_div = i_w_div[lp_lsb +: p_div_width];
`ifdef CLKDIV_DUTY_EN
        assign w_high = i_w_high[lp_lsb +: p_div_width];
`else
        // Fixed duty: odd divisors get the shorter phase high
        assign w_high = w_div >> 1;
`endif

        clk_div_channel #(
            .p_div_width (p_div_width)
        ) u_ch (
            .i_w_clk    (i_w_clk),
            .i_w_reset  (i_w_reset),
            .i_w_en     (i_w_en[g]),
            .i_w_sync   (i_w_sync),
            .i_w_div    (w_div),
            .i_w_high   (w_high),
            .o_w_clk    (o_w_clk[g]),
            .o_w_tick   (o_w_tick[g]),
            .o_w_active (o_w_active[g])
        );
    end

endmodule
